// File: rtl/floo_pkg.sv
// rtl/floo_pkg.sv - types, states and direction helper for the ring-on-mesh multicast injector
package floo_pkg;

    localparam int NumRingNodes = 8;
    localparam int IdWidth      = $clog2(NumRingNodes);

    typedef logic [IdWidth-1:0]      id_t;
    typedef logic [NumRingNodes-1:0] mask_t;

    typedef struct packed {
        id_t   dst_id;
        logic  last;
        logic  ring_on_mesh_mcast;
        logic  up_down_traffic;
        mask_t ring_on_mesh_dst_mask;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [31:0] payload;
    } flit_t;

    typedef enum logic [2:0] {
        IDLE,
        PASS,
        FIRST,
        REPLAY,
        DROP
    } rom_mcast_state_e;

    typedef struct packed {
        logic has_up;
        id_t  up_dst;
        logic has_down;
        id_t  down_dst;
    } rom_mcast_dirs_t;

    // Farthest target on each side of own; own bit never counts as a target.
    function automatic rom_mcast_dirs_t rom_mcast_dirs(input mask_t mask, input id_t own);
        rom_mcast_dirs_t d;
        d = '0;
        for (int i = 0; i < NumRingNodes; i++) begin
            if (mask[i] && i > int'(own)) begin
                d.has_up = 1'b1;
                d.up_dst = id_t'(i);
            end
        end
        for (int i = NumRingNodes - 1; i >= 0; i--) begin
            if (mask[i] && i < int'(own)) begin
                d.has_down = 1'b1;
                d.down_dst = id_t'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/floo_rom_mcast_dst_calc.sv
// rtl/floo_rom_mcast_dst_calc.sv - leading/trailing-one finder above and below own ring id
module floo_rom_mcast_dst_calc
    import floo_pkg::*;
(
    input  mask_t           mask_i,
    input  id_t             own_i,
    output rom_mcast_dirs_t dirs_o
);

    assign dirs_o = rom_mcast_dirs(mask_i, own_i);

endmodule

// File: rtl/floo_ring_on_mesh_mcast_injector.sv
// rtl/floo_ring_on_mesh_mcast_injector.sv - splits multicast bursts into UP/DOWN copies; FLOO_ROM_MCAST_STATS_EN adds copy counter
module floo_ring_on_mesh_mcast_injector
    import floo_pkg::*;
#(
    parameter int unsigned MaxBurstLen = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  id_t         ring_on_mesh_id_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  flit_t       channel_i,
    output logic        valid_o,
    input  logic        ready_i,
    output flit_t       channel_o,
    output logic        err_o,
    output logic [31:0] stats_o
);

    localparam int unsigned AW = (MaxBurstLen > 1) ? $clog2(MaxBurstLen) : 1;
    localparam int unsigned CW = $clog2(MaxBurstLen + 1);

    rom_mcast_state_e state_q, state_d, mode;
    rom_mcast_dirs_t  dirs_in, dirs_q, dirs_d, dirs;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    flit_t            buf_q [MaxBurstLen];
    logic             is_idle, both, full, rd_last, buf_we, in_hs, out_hs;

    floo_rom_mcast_dst_calc i_dst_calc (
        .mask_i (channel_i.hdr.ring_on_mesh_dst_mask),
        .own_i  (ring_on_mesh_id_i),
        .dirs_o (dirs_in)
    );

    // The head flit is classified live so it can cut through in the same cycle.
    always_comb begin
        is_idle = (state_q == IDLE);
        dirs    = is_idle ? dirs_in : dirs_q;
        both    = dirs.has_up && dirs.has_down;
        full    = (cnt_q == CW'(MaxBurstLen));
        rd_last = (CW'(rd_ptr_q) == cnt_q - CW'(1));
        mode    = state_q;
        if (is_idle && valid_i) begin
            if (!channel_i.hdr.ring_on_mesh_mcast) begin
                mode = PASS;
            end else if (channel_i.hdr.ring_on_mesh_dst_mask == '0) begin
                mode = DROP;
            end else begin
                mode = FIRST;
            end
        end
        valid_o   = 1'b0;
        ready_o   = 1'b0;
        err_o     = 1'b0;
        channel_o = channel_i;
        case (mode)
            PASS: begin
                valid_o = valid_i;
                ready_o = ready_i;
            end
            FIRST: begin
                valid_o = valid_i;
                ready_o = ready_i;
                channel_o.hdr.up_down_traffic = dirs.has_up || !dirs.has_down;
                channel_o.hdr.dst_id = dirs.has_up   ? dirs.up_dst   :
                                       dirs.has_down ? dirs.down_dst : ring_on_mesh_id_i;
                err_o = valid_i && ready_i && full;
            end
            DROP: begin
                ready_o = 1'b1;
                err_o   = is_idle && valid_i;
            end
            REPLAY: begin
                valid_o   = 1'b1;
                channel_o = buf_q[rd_ptr_q];
                channel_o.hdr.up_down_traffic = 1'b0;
                channel_o.hdr.dst_id          = dirs_q.down_dst;
                channel_o.hdr.ring_on_mesh_dst_mask[ring_on_mesh_id_i] = 1'b0;
                channel_o.hdr.last            = rd_last;
            end
            default: ;
        endcase
        if (rst_i) begin
            valid_o = 1'b0;
            ready_o = 1'b0;
            err_o   = 1'b0;
        end
    end

    assign in_hs  = valid_i && ready_o;
    assign out_hs = valid_o && ready_i;

    always_comb begin
        state_d  = state_q;
        dirs_d   = dirs_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        buf_we   = 1'b0;
        case (mode)
            PASS, DROP: begin
                if (in_hs) state_d = channel_i.hdr.last ? IDLE : mode;
            end
            FIRST: begin
                if (in_hs) begin
                    dirs_d = dirs;
                    buf_we = both && !full;
                    if (buf_we) wr_ptr_d = (wr_ptr_q == AW'(MaxBurstLen - 1)) ? '0 : wr_ptr_q + AW'(1);
                    if (!full) cnt_d = cnt_q + CW'(1);
                    state_d = FIRST;
                    if (channel_i.hdr.last) begin
                        state_d = both ? REPLAY : IDLE;
                        if (!both) begin
                            cnt_d    = '0;
                            wr_ptr_d = '0;
                        end
                    end
                end
            end
            REPLAY: begin
                if (out_hs) begin
                    rd_ptr_d = (rd_ptr_q == AW'(MaxBurstLen - 1)) ? '0 : rd_ptr_q + AW'(1);
                    if (rd_last) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            dirs_q   <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            dirs_q   <= dirs_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (buf_we) buf_q[wr_ptr_q] <= channel_i;
    end

`ifdef FLOO_ROM_MCAST_STATS_EN
    logic [31:0] stats_q;
    logic        copy_head;

    assign copy_head = (is_idle && mode == FIRST && in_hs) ||
                       (state_q == REPLAY && rd_ptr_q == '0 && out_hs);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stats_q <= '0;
        end else if (copy_head && stats_q != '1) begin
            stats_q <= stats_q + 32'd1;
        end
    end

    assign stats_o = stats_q;
`else
    assign stats_o = '0;
`endif

endmodule

// File: tb/tb_floo_ring_on_mesh_mcast_injector.sv
// tb/tb_floo_ring_on_mesh_mcast_injector.sv - self-checking bench for the ring-on-mesh multicast injector
module tb_floo_ring_on_mesh_mcast_injector;
    import floo_pkg::*;

    localparam int MAX = 8;

    logic        clk = 1'b0;
    logic        rst, valid_i, ready_i, ready_o, valid_o, err_o;
    id_t         own_id;
    flit_t       channel_i, channel_o;
    logic [31:0] stats_o;

    floo_ring_on_mesh_mcast_injector #(.MaxBurstLen(MAX)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ring_on_mesh_id_i (own_id),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .channel_i         (channel_i),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .channel_o         (channel_o),
        .err_o             (err_o),
        .stats_o           (stats_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          own;
        bit          mcast;
        logic [7:0]  mask;
        int          len;
        int          exp_outs;
        int          exp_errs;
        bit          chk_hdr;
        bit          exp_ud;
        int          exp_dst;
    } vec_t;

    vec_t  vecs [10];
    flit_t src_q[$], exp_q[$], got_q[$];
    int    tests = 0, failed = 0;
    int    errs_seen = 0, exp_errs = 0, exp_stats = 0;
    int    n_acc = 0, n_out = 0;
    int    rdy_pct = 100, vld_pct = 100;
    bit    rdy_toggle = 0, guard_on = 0, prev_stall = 0;
    int    guard_acc, guard_out, guard_viol = 0, stab_viol = 0;
    flit_t prev_ch;
    int    seg_own, a0, wait_n, rsel;
    logic [7:0] seg_mask;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int stat_exp();
`ifdef FLOO_ROM_MCAST_STATS_EN
        return exp_stats;
`else
        return 0;
`endif
    endfunction

    // Reference model: what the ring should see for one burst, straight from the splitting rules.
    task automatic add_burst(input int own, input bit mcast, input logic [7:0] mask, input int len);
        flit_t bq[$];
        flit_t f;
        int up = -1, dn = -1, k;
        for (int l = 0; l < len; l++) begin
            f = '0;
            f.payload                   = $urandom;
            f.hdr.dst_id                = id_t'($urandom_range(7));
            f.hdr.up_down_traffic       = 1'($urandom_range(1));
            f.hdr.ring_on_mesh_mcast    = mcast;
            f.hdr.ring_on_mesh_dst_mask = mask;
            f.hdr.last                  = (l == len - 1);
            bq.push_back(f);
            src_q.push_back(f);
        end
        if (!mcast) begin
            foreach (bq[l]) exp_q.push_back(bq[l]);
        end else if (mask == 0) begin
            exp_errs++;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i] && i > own) up = i;
                if (mask[i] && i < own && dn < 0) dn = i;
            end
            exp_stats++;
            foreach (bq[l]) begin
                f = bq[l];
                f.hdr.up_down_traffic = (up >= 0) || (dn < 0);
                f.hdr.dst_id = id_t'((up >= 0) ? up : (dn >= 0) ? dn : own);
                exp_q.push_back(f);
            end
            if (len > MAX) exp_errs += len - MAX;
            if (up >= 0 && dn >= 0) begin
                k = (len < MAX) ? len : MAX;
                exp_stats++;
                for (int l = 0; l < k; l++) begin
                    f = bq[l];
                    f.hdr.up_down_traffic = 1'b0;
                    f.hdr.dst_id = id_t'(dn);
                    f.hdr.ring_on_mesh_dst_mask[own] = 1'b0;
                    f.hdr.last = (l == k - 1);
                    exp_q.push_back(f);
                end
            end
        end
    endtask

    task automatic refresh();
        if (!valid_i) valid_i = (src_q.size() > 0) && ($urandom_range(99) < vld_pct);
        channel_i = (src_q.size() > 0) ? src_q[0] : '0;
    endtask

    task automatic tick();
        logic acc;
        @(negedge clk);
        acc = valid_i && ready_o;
        if (guard_on && ready_o && n_acc >= guard_acc && n_out < guard_out) guard_viol++;
        if (prev_stall && (!valid_o || channel_o != prev_ch)) stab_viol++;
        prev_stall = valid_o && !ready_i;
        prev_ch    = channel_o;
        if (valid_o && ready_i) begin
            got_q.push_back(channel_o);
            n_out++;
        end
        if (err_o) errs_seen++;
        if (acc) n_acc++;
        @(posedge clk);
        #1;
        if (acc) begin
            void'(src_q.pop_front());
            valid_i = 1'b0;
        end
        refresh();
        ready_i = rdy_toggle ? !ready_i : ($urandom_range(99) < rdy_pct);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((src_q.size() > 0 || got_q.size() < exp_q.size()) && n < 2000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        tests++;
        if (n >= 2000) begin
            failed++;
            $display("FAIL %s timeout: %0d flits unsent, %0d of %0d outputs", name, src_q.size(), got_q.size(), exp_q.size());
        end
    endtask

    task automatic check_stream(input string name);
        int bad = -1;
        tests++;
        if (got_q.size() != exp_q.size()) begin
            failed++;
            $display("FAIL %s flit count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
            if (bad >= 0) begin
                failed++;
                $display("FAIL %s flit %0d: got %h expected %h", name, bad, got_q[bad], exp_q[bad]);
            end
        end
        chk({name, " err pulses"}, errs_seen, exp_errs);
        chk({name, " stats"}, stats_o, stat_exp());
        got_q.delete();
        exp_q.delete();
        errs_seen = 0;
        exp_errs  = 0;
    endtask

    initial begin
        vecs[0] = '{3, 1'b0, 8'hFF,        3,  3, 0, 1'b0, 1'b0, 0};
        vecs[1] = '{3, 1'b1, 8'b1001_0010, 2,  4, 0, 1'b1, 1'b1, 7};
        vecs[2] = '{3, 1'b1, 8'b0000_1011, 2,  2, 0, 1'b1, 1'b0, 0};
        vecs[3] = '{0, 1'b1, 8'b0000_0001, 1,  1, 0, 1'b1, 1'b1, 0};
        vecs[4] = '{0, 1'b1, 8'b0000_0000, 2,  0, 1, 1'b0, 1'b0, 0};
        vecs[5] = '{3, 1'b1, 8'b0110_1000, 1,  1, 0, 1'b1, 1'b1, 6};
        vecs[6] = '{7, 1'b1, 8'b1000_0001, 2,  2, 0, 1'b1, 1'b0, 0};
        vecs[7] = '{0, 1'b1, 8'b1111_1110, 3,  3, 0, 1'b1, 1'b1, 7};
        vecs[8] = '{3, 1'b1, 8'b1001_0010, 10, 18, 2, 1'b1, 1'b1, 7};
        vecs[9] = '{7, 1'b1, 8'b1000_0000, 1,  1, 0, 1'b1, 1'b1, 7};

        rst       = 1'b1;
        own_id    = '0;
        valid_i   = 1'b1;
        ready_i   = 1'b1;
        channel_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset valid_o", valid_o, 0);
        chk("reset ready_o", ready_o, 0);
        chk("reset err_o", err_o, 0);
        chk("reset stats_o", stats_o, 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        valid_i = 1'b0;

        // Unicast cut-through: one flit out per cycle from the first cycle.
        own_id = 5;
        add_burst(5, 1'b0, 8'h3C, 3);
        refresh();
        repeat (3) tick();
        chk("unicast zero latency", got_q.size(), 3);
        drain("unicast");
        check_stream("unicast");

        foreach (vecs[v]) begin
            own_id = id_t'(vecs[v].own);
            add_burst(vecs[v].own, vecs[v].mcast, vecs[v].mask, vecs[v].len);
            refresh();
            drain($sformatf("vec%0d", v));
            chk($sformatf("vec%0d outputs", v), got_q.size(), vecs[v].exp_outs);
            chk($sformatf("vec%0d errs", v), errs_seen, vecs[v].exp_errs);
            if (vecs[v].chk_hdr && got_q.size() > 0) begin
                chk($sformatf("vec%0d first ud", v), got_q[0].hdr.up_down_traffic, vecs[v].exp_ud);
                chk($sformatf("vec%0d first dst", v), got_q[0].hdr.dst_id, vecs[v].exp_dst);
            end
            check_stream($sformatf("vec%0d model", v));
        end

        // Replay under toggling ready_i, with the next head queued right behind.
        own_id     = 3;
        rdy_toggle = 1'b1;
        guard_acc  = n_acc + 2;
        guard_out  = n_out + 4;
        guard_viol = 0;
        add_burst(3, 1'b1, 8'b1001_0010, 2);
        add_burst(3, 1'b0, 8'h00, 1);
        refresh();
        guard_on = 1'b1;
        drain("replay toggle");
        guard_on   = 1'b0;
        rdy_toggle = 1'b0;
        chk("replay keeps ready_o low", guard_viol, 0);
        check_stream("replay toggle");

        // Reset in the middle of a two-direction burst: no partial replay afterwards.
        own_id = 3;
        a0     = n_acc;
        add_burst(3, 1'b1, 8'b1001_0010, 4);
        refresh();
        wait_n = 0;
        while (n_acc < a0 + 2 && wait_n < 200) begin
            tick();
            wait_n++;
        end
        chk("mid-burst accepted before reset", n_acc - a0, 2);
        rst       = 1'b1;
        src_q.delete();
        valid_i   = 1'b1;
        ready_i   = 1'b1;
        channel_i = '0;
        @(negedge clk);
        chk("mid reset valid_o", valid_o, 0);
        chk("mid reset ready_o", ready_o, 0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        valid_i    = 1'b0;
        prev_stall = 1'b0;
        got_q.delete();
        exp_q.delete();
        errs_seen = 0;
        exp_errs  = 0;
        exp_stats = 0;
        add_burst(3, 1'b0, 8'h00, 2);
        refresh();
        drain("after reset");
        check_stream("after reset");

        // Random segments, own id fixed within each.
        rdy_pct = 70;
        vld_pct = 80;
        for (int s = 0; s < 12; s++) begin
            seg_own = $urandom_range(7);
            own_id  = id_t'(seg_own);
            for (int b = 0; b < 3; b++) begin
                rsel     = $urandom_range(9);
                seg_mask = 8'($urandom);
                if (rsel == 0) seg_mask = 8'h00;
                else if (rsel == 1) seg_mask = 8'(1 << seg_own);
                add_burst(seg_own, $urandom_range(4) != 0, seg_mask, $urandom_range(1, 10));
            end
            refresh();
            drain($sformatf("rand%0d", s));
            check_stream($sformatf("rand%0d", s));
        end

        chk("valid_o/channel_o stable while stalled", stab_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
